// File: rtl/core_local_timer.sv
// Machine timer / software interrupt block: mtime, mtimecmp and msip on the data bus.
// Optional tick prescaler is enabled by defining CLINT_TICK_PRESCALER_EN.
module core_local_timer #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [1:0]  wr_width,
    input  logic [4:0]  raddr,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mtimer_int,
    output logic        msoftware_int
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mtimer_int_q, mtimer_int_d;
    logic        msoftware_int_q, msoftware_int_d;
    logic [3:0]  be;
    logic        wr, rd;
    logic        tick;
    logic        unused_raddr;

    assign unused_raddr = ^raddr[1:0];

`ifdef CLINT_TICK_PRESCALER_EN
    logic [15:0] presc_q, presc_d;

    assign tick = (presc_q == 16'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) presc_q <= 16'd0;
        else          presc_q <= presc_d;
    end
`else
    logic unused_div;

    assign unused_div = (TICK_DIV == 0);
    assign tick       = 1'b1;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  en);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = en[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Misaligned and reserved-width writes get no lanes, so they leave state alone
    always_comb begin
        be = 4'b0000;
        case (wr_width)
            2'b00: be = 4'b0001 << waddr[1:0];
            2'b01: if (!waddr[0]) be = waddr[1] ? 4'b1100 : 4'b0011;
            2'b10: if (waddr[1:0] == 2'b00) be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wr = sel & wr_en & (|be);
    assign rd = sel & rd_en;

    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && waddr[4:2] == 3'd4)
            mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata, be)};
        if (wr && waddr[4:2] == 3'd5)
            mtime_d = {merge(mtime_q[63:32], wdata, be), mtime_q[31:0]};

        mtimecmp_d = mtimecmp_q;
        if (wr && waddr[4:2] == 3'd2)
            mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], wdata, be);
        if (wr && waddr[4:2] == 3'd3)
            mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, be);

        msip_d = msip_q;
        if (wr && waddr[4:2] == 3'd0 && be[0])
            msip_d = wdata[0];

        rdata_d = rdata_q;
        if (rd) begin
            case (raddr[4:2])
                3'd0:    rdata_d = {31'd0, msip_q};
                3'd2:    rdata_d = mtimecmp_q[31:0];
                3'd3:    rdata_d = mtimecmp_q[63:32];
                3'd4:    rdata_d = mtime_q[31:0];
                3'd5:    rdata_d = mtime_q[63:32];
                default: rdata_d = 32'd0;
            endcase
        end

        mtimer_int_d    = (mtime_q >= mtimecmp_q);
        msoftware_int_d = msip_q;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            mtime_q         <= 64'd0;
            mtimecmp_q      <= MTIMECMP_RST;
            msip_q          <= 1'b0;
            rdata_q         <= 32'd0;
            mtimer_int_q    <= 1'b0;
            msoftware_int_q <= 1'b0;
        end else begin
            mtime_q         <= mtime_d;
            mtimecmp_q      <= mtimecmp_d;
            msip_q          <= msip_d;
            rdata_q         <= rdata_d;
            mtimer_int_q    <= mtimer_int_d;
            msoftware_int_q <= msoftware_int_d;
        end
    end

    assign rdata         = rdata_q;
    assign mtimer_int    = mtimer_int_q;
    assign msoftware_int = msoftware_int_q;

endmodule
